// File: rtl/usb_hid_pkg.sv
// Shared types and constants for the USB HID keyboard event path.
// Report snapshot layout, event encoding and scan FSM states.
package usb_hid_pkg;

   localparam logic [1:0] USB_TYP_KBD      = 2'd1;
   localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
   localparam logic [7:0] MOD_USAGE_BASE   = 8'hE0;

   typedef struct packed {
      logic       pressed;
      logic [7:0] code;
   } kbd_evt_t;

   typedef struct packed {
      logic [7:0]      mods;
      logic [3:0][7:0] keys;
   } kbd_report_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOD,
      ST_REL,
      ST_PRS,
      ST_COMMIT
   } kbd_state_e;

   // true when code matches any of keys[0..lim-1]
   function automatic logic key_hit(
      input logic [7:0]      code,
      input logic [3:0][7:0] keys,
      input logic [2:0]      lim
   );
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if (j < int'(lim) && keys[j] == code) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/usb_kbd_event_gen_if.sv
// Valid/ready stream carrying keyboard make/break events.
// master drives valid/data, slave drives ready.
interface kbd_evt_if;
   import usb_hid_pkg::*;

   logic     evt_valid;
   kbd_evt_t evt_data;
   logic     evt_ready;

   modport master (
      output evt_valid,
      output evt_data,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_data,
      output evt_ready
   );

endinterface

// File: rtl/kbd_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for keyboard events.
// Drops writes when full unless a read frees a slot the same cycle.
module kbd_evt_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     rd_valid,
   output logic [WIDTH-1:0]         rd_data,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic [WIDTH-1:0] last_q;
   logic             full;
   logic             pop;
   logic             wr_ok;

   assign full     = (cnt == FULL_CNT);
   assign rd_valid = (cnt != '0);
   assign pop      = rd_valid & rd_ready;
   assign wr_ok    = wr_en & (~full | pop);
   assign drop     = wr_en & full & ~pop;
   assign count    = cnt;
   // empty output keeps showing the last popped word
   assign rd_data  = rd_valid ? mem[rd_ptr] : last_q;

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         last_q <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr];
         end
         cnt <= cnt + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
      end
   end

endmodule

// File: rtl/usb_kbd_event_gen.sv
// Diffs successive HID keyboard reports into make/break events.
// Fixed 17-cycle scan per report; one pending report buffered.
module usb_kbd_event_gen
   import usb_hid_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          wb_clk,
   input  logic                          wb_rst,
   input  logic                          usb_report_stb,
   input  logic [1:0]                    usb_typ,
   input  logic [7:0]                    usb_key_modifiers,
   input  logic [7:0]                    usb_key1,
   input  logic [7:0]                    usb_key2,
   input  logic [7:0]                    usb_key3,
   input  logic [7:0]                    usb_key4,
   kbd_evt_if.master                     evt,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic                          busy
);

   kbd_state_e  state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   kbd_report_t cur_q, prev_q, pend_q;
   kbd_report_t snap;
   logic        pend_vld_q;
   logic        is_kbd;
   logic        rollover;
   logic        snap_ok;
   logic        load_pend;
   logic        load_snap;
   logic        commit;
   logic        push;
   kbd_evt_t    push_evt;
   logic [7:0]  pk;
   logic [7:0]  nk;
   logic        drop;

   assign is_kbd   = (usb_typ == USB_TYP_KBD);
   assign rollover = is_kbd & (usb_key1 == KEY_ERR_ROLLOVER |
                               usb_key2 == KEY_ERR_ROLLOVER |
                               usb_key3 == KEY_ERR_ROLLOVER |
                               usb_key4 == KEY_ERR_ROLLOVER);
   assign snap_ok  = usb_report_stb & ~rollover;
   // non-keyboard devices look like release-all
   assign snap     = is_kbd ?
      kbd_report_t'({usb_key_modifiers, usb_key4, usb_key3, usb_key2, usb_key1}) :
      '0;
   assign busy     = (state_q != ST_IDLE) | pend_vld_q;

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q + 3'd1;
      load_pend = 1'b0;
      load_snap = 1'b0;
      commit    = 1'b0;
      push      = 1'b0;
      push_evt  = '0;
      pk        = prev_q.keys[idx_q[1:0]];
      nk        = cur_q.keys[idx_q[1:0]];
      unique case (state_q)
         ST_IDLE: begin
            idx_d = '0;
            if (pend_vld_q) begin
               load_pend = 1'b1;
               state_d   = ST_MOD;
            end else if (snap_ok) begin
               load_snap = 1'b1;
               state_d   = ST_MOD;
            end
         end
         ST_MOD: begin
            if (cur_q.mods[idx_q] != prev_q.mods[idx_q]) begin
               push             = 1'b1;
               push_evt.pressed = cur_q.mods[idx_q];
               push_evt.code    = MOD_USAGE_BASE + {5'd0, idx_q};
            end
            if (idx_q == 3'd7) begin
               state_d = ST_REL;
               idx_d   = '0;
            end
         end
         ST_REL: begin
            if (pk != 8'h00 && !key_hit(pk, cur_q.keys, 3'd4) &&
                !key_hit(pk, prev_q.keys, idx_q)) begin
               push             = 1'b1;
               push_evt.pressed = 1'b0;
               push_evt.code    = pk;
            end
            if (idx_q == 3'd3) begin
               state_d = ST_PRS;
               idx_d   = '0;
            end
         end
         ST_PRS: begin
            if (nk != 8'h00 && !key_hit(nk, prev_q.keys, 3'd4) &&
                !key_hit(nk, cur_q.keys, idx_q)) begin
               push             = 1'b1;
               push_evt.pressed = 1'b1;
               push_evt.code    = nk;
            end
            if (idx_q == 3'd3) begin
               state_d = ST_COMMIT;
               idx_d   = '0;
            end
         end
         ST_COMMIT: begin
            commit  = 1'b1;
            state_d = ST_IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         cur_q      <= '0;
         prev_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         if (load_pend) cur_q <= pend_q;
         else if (load_snap) cur_q <= snap;
         if (commit) prev_q <= cur_q;
         // newest report wins the pending slot
         if (snap_ok && (state_q != ST_IDLE || pend_vld_q)) begin
            pend_q     <= snap;
            pend_vld_q <= 1'b1;
         end else if (load_pend) begin
            pend_vld_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
   end

   kbd_evt_fifo #(
      .WIDTH ($bits(kbd_evt_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (wb_clk),
      .rst      (wb_rst),
      .wr_en    (push),
      .wr_data  (push_evt),
      .rd_valid (evt.evt_valid),
      .rd_data  (evt.evt_data),
      .rd_ready (evt.evt_ready),
      .count    (evt_count),
      .drop     (drop)
   );

endmodule

// File: tb/tb_usb_kbd_event_gen.sv
// Directed bench: scoreboarded event stream plus a shallow-FIFO instance.
// Expected events are queued at stimulus time and popped by a monitor.
module tb_usb_kbd_event_gen;
   import usb_hid_pkg::*;

   logic       wb_clk = 1'b0;
   logic       wb_rst = 1'b1;
   logic       rst_o  = 1'b1;
   logic       stb    = 1'b0;
   logic       stb_o  = 1'b0;
   logic [1:0] typ    = 2'd0;
   logic [7:0] mods   = 8'h00;
   logic [7:0] k1 = 8'h00, k2 = 8'h00, k3 = 8'h00, k4 = 8'h00;
   logic       clr    = 1'b0;
   logic       clr_o  = 1'b0;
   logic [4:0] cnt_m;
   logic [1:0] cnt_o;
   logic       ovf_m, ovf_o;
   logic       busy_m, busy_o;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];

   kbd_evt_if evt_m ();
   kbd_evt_if evt_o ();

   always #5 wb_clk = ~wb_clk;

   usb_kbd_event_gen #(.FIFO_DEPTH(16)) u_dut (
      .wb_clk            (wb_clk),
      .wb_rst            (wb_rst),
      .usb_report_stb    (stb),
      .usb_typ           (typ),
      .usb_key_modifiers (mods),
      .usb_key1          (k1),
      .usb_key2          (k2),
      .usb_key3          (k3),
      .usb_key4          (k4),
      .evt               (evt_m.master),
      .evt_count         (cnt_m),
      .overflow          (ovf_m),
      .clr_overflow      (clr),
      .busy              (busy_m)
   );

   usb_kbd_event_gen #(.FIFO_DEPTH(2)) u_ovf (
      .wb_clk            (wb_clk),
      .wb_rst            (rst_o),
      .usb_report_stb    (stb_o),
      .usb_typ           (typ),
      .usb_key_modifiers (mods),
      .usb_key1          (k1),
      .usb_key2          (k2),
      .usb_key3          (k3),
      .usb_key4          (k4),
      .evt               (evt_o.master),
      .evt_count         (cnt_o),
      .overflow          (ovf_o),
      .clr_overflow      (clr_o),
      .busy              (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic set_rpt(input logic [1:0] t, input logic [7:0] m,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
      typ = t; mods = m; k1 = a; k2 = b; k3 = c; k4 = d;
   endtask

   task automatic send(input logic [1:0] t, input logic [7:0] m,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
      set_rpt(t, m, a, b, c, d);
      stb = 1'b1;
      step();
      stb = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy_m || evt_m.evt_valid) && n < 300) begin
         step();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < 300), 32'd1);
      chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic monitor();
      logic [8:0] e;
      forever begin
         @(negedge wb_clk);
         if (evt_m.evt_valid && evt_m.evt_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++;
               $error("FAIL evt_extra got=%h exp=none", evt_m.evt_data);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               assert (evt_m.evt_data === e) else begin
                  errors++;
                  $error("FAIL evt_data got=%h exp=%h", evt_m.evt_data, e);
               end
            end
         end
      end
   endtask

   initial begin
      int n;
      evt_m.evt_ready = 1'b1;
      evt_o.evt_ready = 1'b0;
      fork
         monitor();
      join_none
      repeat (3) step();
      wb_rst = 1'b0;
      rst_o  = 1'b0;
      step();

      chk("rst_valid", 32'(evt_m.evt_valid), 32'd0);
      chk("rst_count", 32'(cnt_m), 32'd0);
      chk("rst_ovf", 32'(ovf_m), 32'd0);
      chk("rst_busy", 32'(busy_m), 32'd0);

      // press A, measure scan length
      exp_q.push_back(9'h104);
      send(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
      n = 0;
      while (busy_m && n < 100) begin
         step();
         n++;
      end
      chk("busy_len", 32'(n), 32'd17);
      wait_idle("press_a");

      exp_q.push_back(9'h004);
      send(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle("rel_a");

      // shift+A then release all
      exp_q.push_back(9'h1E1);
      exp_q.push_back(9'h104);
      send(2'd1, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
      wait_idle("shift_a");
      exp_q.push_back(9'h0E1);
      exp_q.push_back(9'h004);
      send(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle("shift_rel");

      // roll with duplicate slots
      exp_q.push_back(9'h104);
      exp_q.push_back(9'h105);
      send(2'd1, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00);
      wait_idle("roll_pre");
      exp_q.push_back(9'h004);
      exp_q.push_back(9'h106);
      send(2'd1, 8'h00, 8'h05, 8'h06, 8'h06, 8'h00);
      wait_idle("roll_dup");
      exp_q.push_back(9'h005);
      exp_q.push_back(9'h006);
      send(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle("roll_rel");

      // rollover report is discarded
      exp_q.push_back(9'h104);
      send(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
      wait_idle("ro_pre");
      send(2'd1, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01);
      chk("ro_busy", 32'(busy_m), 32'd0);
      wait_idle("ro_none");
      exp_q.push_back(9'h004);
      send(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle("ro_rel");

      // unplug releases everything
      exp_q.push_back(9'h104);
      exp_q.push_back(9'h105);
      send(2'd1, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00);
      wait_idle("unp_pre");
      exp_q.push_back(9'h004);
      exp_q.push_back(9'h005);
      send(2'd0, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00);
      wait_idle("unplug");

      // back-to-back reports during a scan: newest pending wins
      exp_q.push_back(9'h107);
      exp_q.push_back(9'h007);
      exp_q.push_back(9'h10A);
      set_rpt(2'd1, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00);
      stb = 1'b1;
      step();
      k1 = 8'h08;
      step();
      k1 = 8'h09;
      step();
      k1 = 8'h0A;
      step();
      stb = 1'b0;
      chk("pend_busy", 32'(busy_m), 32'd1);
      wait_idle("b2b");
      exp_q.push_back(9'h00A);
      send(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle("b2b_rel");

      // shallow FIFO with stalled consumer
      set_rpt(2'd1, 8'h00, 8'h04, 8'h05, 8'h06, 8'h07);
      stb_o = 1'b1;
      step();
      stb_o = 1'b0;
      n = 0;
      while (busy_o && n < 100) begin
         step();
         n++;
      end
      chk("ovf_scan", 32'(n), 32'd17);
      chk("ovf_count", 32'(cnt_o), 32'd2);
      chk("ovf_flag", 32'(ovf_o), 32'd1);
      chk("ovf_valid", 32'(evt_o.evt_valid), 32'd1);
      chk("ovf_head", 32'(evt_o.evt_data), 32'h104);
      clr_o = 1'b1;
      step();
      clr_o = 1'b0;
      chk("ovf_clr", 32'(ovf_o), 32'd0);
      evt_o.evt_ready = 1'b1;
      step();
      evt_o.evt_ready = 1'b0;
      chk("ovf_pop_cnt", 32'(cnt_o), 32'd1);
      chk("ovf_pop_head", 32'(evt_o.evt_data), 32'h105);

      // reset in the middle of a release scan
      set_rpt(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      stb_o = 1'b1;
      step();
      stb_o = 1'b0;
      repeat (10) step();
      rst_o = 1'b1;
      step();
      rst_o = 1'b0;
      chk("mrst_valid", 32'(evt_o.evt_valid), 32'd0);
      chk("mrst_count", 32'(cnt_o), 32'd0);
      chk("mrst_busy", 32'(busy_o), 32'd0);
      chk("mrst_ovf", 32'(ovf_o), 32'd0);
      repeat (30) step();
      chk("mrst_quiet", 32'(evt_o.evt_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
